ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage_pkg.sv | 47 ++++
 rtl/ex_divider.sv | 102 ++++++++++
 rtl/ex_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared cpu package: widths, operator/category codes, divider states
package ex_stage_pkg;

  localparam int OP_W       = 8;
  localparam int CAT_W      = 3;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // Result class chosen by decode
  typedef enum logic [CAT_W-1:0] {
    CAT_NOP   = 3'd0,
    CAT_LOGIC = 3'd1,
    CAT_SHIFT = 3'd2,
    CAT_MOVE  = 3'd3
  } alu_cat_e;

  // Operator codes; immediate forms (ORI/ANDI/XORI/LUI) and variable shifts reuse these
  localparam logic [OP_W-1:0] OP_NOP  = 8'h00;
  localparam logic [OP_W-1:0] OP_AND  = 8'h24;
  localparam logic [OP_W-1:0] OP_OR   = 8'h25;
  localparam logic [OP_W-1:0] OP_XOR  = 8'h26;
  localparam logic [OP_W-1:0] OP_NOR  = 8'h27;
  localparam logic [OP_W-1:0] OP_SLL  = 8'h7C;
  localparam logic [OP_W-1:0] OP_SRL  = 8'h02;
  localparam logic [OP_W-1:0] OP_SRA  = 8'h03;
  localparam logic [OP_W-1:0] OP_MOVZ = 8'h0A;
  localparam logic [OP_W-1:0] OP_MOVN = 8'h0B;
  localparam logic [OP_W-1:0] OP_MFHI = 8'h10;
  localparam logic [OP_W-1:0] OP_MTHI = 8'h11;
  localparam logic [OP_W-1:0] OP_MFLO = 8'h12;
  localparam logic [OP_W-1:0] OP_MTLO = 8'h13;
  localparam logic [OP_W-1:0] OP_DIV  = 8'h1A;
  localparam logic [OP_W-1:0] OP_DIVU = 8'h1B;

  // Iterative divider states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Magnitude of an operand; unsigned operands pass through untouched
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v, input logic is_signed);
    return (is_signed && v[DATA_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_divider.sv
// rtl/ex_divider.sv - restoring 1-bit/cycle divider, 32 iterations, sign fix-up on the outputs
module ex_divider
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              annul,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  div_state_e        state_q;
  logic [4:0]        count_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] dvs_q;
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic              dvs_zero_q;
  logic              busy_q;
  logic              done_q;

  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] sub;
  logic              fits;

  // Shift the next dividend bit into the partial remainder; the low 32 bits of
  // the wrapped subtraction are exact whenever the divisor fits
  assign trial = {rem_q, quo_q[DATA_W-1]};
  assign fits  = (trial >= {1'b0, dvs_q});
  assign sub   = trial[DATA_W-1:0] - dvs_q;

  // Divide FSM and datapath; annul or reset returns to IDLE without producing a result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= DIV_IDLE;
      count_q    <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dvs_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (annul) begin
      state_q <= DIV_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            state_q    <= DIV_RUN;
            busy_q     <= 1'b1;
            count_q    <= '0;
            rem_q      <= '0;
            quo_q      <= abs_val(dividend, is_signed);
            dvs_q      <= abs_val(divisor, is_signed);
            neg_quo_q  <= is_signed && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
            neg_rem_q  <= is_signed && dividend[DATA_W-1];
            dvs_zero_q <= (divisor == '0);
          end
        end
        DIV_RUN: begin
          rem_q <= fits ? sub : trial[DATA_W-1:0];
          quo_q <= {quo_q[DATA_W-2:0], fits};
          if (count_q == 5'd31) begin
            state_q <= DIV_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            count_q <= count_q + 5'd1;
          end
        end
        DIV_DONE: begin
          state_q <= DIV_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= DIV_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  // Divide by zero reports all-ones quotient; remainder sign restores the dividend itself
  assign quotient  = dvs_zero_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
  assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU result, HI/LO registers, iterative divide when EX_DIVIDER_EN is defined
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  annul,
  input  logic [OP_W-1:0]       alu_operator,
  input  logic [CAT_W-1:0]      alu_category,
  input  logic [DATA_W-1:0]     alu_operand1,
  input  logic [DATA_W-1:0]     alu_operand2,
  input  logic                  write_enable,
  input  logic [REG_ADDR_W-1:0] write_addr,
  output logic                  ex_write_enable,
  output logic [REG_ADDR_W-1:0] ex_write_addr,
  output logic [DATA_W-1:0]     ex_write_data,
  output logic [DATA_W-1:0]     hi,
  output logic [DATA_W-1:0]     lo,
  output logic                  stall_request
);

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] alu_result;
  logic [4:0]        shamt;
  logic              div_wb;
  logic [DATA_W-1:0] div_quotient;
  logic [DATA_W-1:0] div_remainder;

  assign shamt = alu_operand1[4:0];

  // Result select by category; unrecognised operator/category pairs give zero
  always_comb begin
    alu_result = '0;
    case (alu_category)
      CAT_LOGIC: begin
        case (alu_operator)
          OP_OR:   alu_result = alu_operand1 | alu_operand2;
          OP_AND:  alu_result = alu_operand1 & alu_operand2;
          OP_XOR:  alu_result = alu_operand1 ^ alu_operand2;
          OP_NOR:  alu_result = ~(alu_operand1 | alu_operand2);
          default: alu_result = '0;
        endcase
      end
      CAT_SHIFT: begin
        case (alu_operator)
          OP_SLL:  alu_result = alu_operand2 << shamt;
          OP_SRL:  alu_result = alu_operand2 >> shamt;
          OP_SRA:  alu_result = $unsigned($signed(alu_operand2) >>> shamt);
          default: alu_result = '0;
        endcase
      end
      CAT_MOVE: begin
        case (alu_operator)
          OP_MFHI:          alu_result = hi_q;
          OP_MFLO:          alu_result = lo_q;
          OP_MOVN, OP_MOVZ: alu_result = alu_operand1;
          default:          alu_result = '0;
        endcase
      end
      default: alu_result = '0;
    endcase
  end

  assign ex_write_enable = write_enable & ~annul & ~reset;
  assign ex_write_addr   = write_addr;
  assign ex_write_data   = reset ? '0 : alu_result;

`ifdef EX_DIVIDER_EN
  logic div_op;
  logic div_start;
  logic div_busy;
  logic div_done;

  assign div_op    = (alu_operator == OP_DIV) || (alu_operator == OP_DIVU);
  assign div_start = div_op && !annul;

  ex_divider u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .is_signed (alu_operator == OP_DIV),
    .dividend  (alu_operand1),
    .divisor   (alu_operand2),
    .annul     (annul),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  // Stall while a divide waits to start in IDLE and for all of RUN; DONE releases the pipe
  assign stall_request = !reset && !annul && (div_busy || (div_op && !div_done));
  assign div_wb        = div_done && !annul;
`else
  assign stall_request = 1'b0;
  assign div_wb        = 1'b0;
  assign div_quotient  = '0;
  assign div_remainder = '0;
`endif

  // HI/LO next state: MTHI/MTLO load operand1, a completing divide overrides them
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (!annul) begin
      if (alu_operator == OP_MTHI) hi_d = alu_operand1;
      if (alu_operator == OP_MTLO) lo_d = alu_operand1;
    end
    if (div_wb) begin
      hi_d = div_remainder;
      lo_d = div_quotient;
    end
  end

  // HI/LO registers
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
